// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage: bus widths, enable/reset
// encodings, the bubble instruction and the state encodings.
package if_stage_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] ZeroWord = '0;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Reset is active-low: rst == RstEnable means reset asserted.
    localparam logic RstEnable = 1'b0;

    // addi x0,x0,0 -- used for every bubble and for the faulting slot.
    localparam logic [InstBus-1:0] NopInst = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'b00,
        IF_RUN   = 2'b01,
        IF_FAULT = 2'b10
    } if_state_e;

    // What the IF/ID register does on the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_BUBBLE = 2'b01,
        IFID_LOAD   = 2'b10
    } ifid_ctrl_e;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_misaligned(input logic [InstAddrBus-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, ROM and IF/ID signals.
// slave is the fetch stage itself; master is whoever drives it.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                   if_stall;
    logic                   id_stall;
    logic                   branch_flag_i;
    logic [InstAddrBus-1:0] branch_target_i;
    logic                   flush_i;
    logic [InstAddrBus-1:0] flush_pc_i;
    logic [InstBus-1:0]     inst_i;
    logic [InstAddrBus-1:0] pc_o;
    logic                   ce_o;
    logic [InstAddrBus-1:0] id_pc_o;
    logic [InstBus-1:0]     id_inst_o;
    logic                   id_valid_o;
    logic                   id_excp_o;

    modport master (
        output if_stall, id_stall, branch_flag_i, branch_target_i,
               flush_i, flush_pc_i, inst_i,
        input  pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o, id_excp_o
    );

    modport slave (
        input  if_stall, id_stall, branch_flag_i, branch_target_i,
               flush_i, flush_pc_i, inst_i,
        output pc_o, ce_o, id_pc_o, id_inst_o, id_valid_o, id_excp_o
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Each edge it either holds, takes a bubble
// (NOP, not valid, no fault) or loads a new {pc, inst, excp} entry.
// A bubble keeps the old pc; decode ignores it when valid is low.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [InstBus-1:0] NOP_INST = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ifid_ctrl_e             ctrl,
    input  logic [InstAddrBus-1:0] load_pc,
    input  logic [InstBus-1:0]     load_inst,
    input  logic                   load_excp,
    output logic [InstAddrBus-1:0] id_pc,
    output logic [InstBus-1:0]     id_inst,
    output logic                   id_valid,
    output logic                   id_excp
);

    logic [InstAddrBus-1:0] id_pc_reg;
    logic [InstBus-1:0]     id_inst_reg;
    logic                   id_valid_reg;
    logic                   id_excp_reg;

    // Pipeline register update: hold, bubble or load.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            id_pc_reg    <= ZeroWord;
            id_inst_reg  <= NOP_INST;
            id_valid_reg <= 1'b0;
            id_excp_reg  <= 1'b0;
        end else begin
            case (ctrl)
                IFID_LOAD: begin
                    id_pc_reg    <= load_pc;
                    id_inst_reg  <= load_inst;
                    id_valid_reg <= 1'b1;
                    id_excp_reg  <= load_excp;
                end
                IFID_BUBBLE: begin
                    id_inst_reg  <= NOP_INST;
                    id_valid_reg <= 1'b0;
                    id_excp_reg  <= 1'b0;
                end
                default: begin
                    id_pc_reg    <= id_pc_reg;
                    id_inst_reg  <= id_inst_reg;
                    id_valid_reg <= id_valid_reg;
                    id_excp_reg  <= id_excp_reg;
                end
            endcase
        end
    end

    assign id_pc    = id_pc_reg;
    assign id_inst  = id_inst_reg;
    assign id_valid = id_valid_reg;
    assign id_excp  = id_excp_reg;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, enables the instruction ROM, and feeds the
// IF/ID register. Handles stalls, branch and flush redirects, and
// faults on misaligned redirect targets. All outputs are registered.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [InstBus-1:0]     NOP_INST = NopInst
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.slave  bus
);

    if_state_e              state_reg;
    if_state_e              state_next;
    logic [InstAddrBus-1:0] pc_reg;
    logic [InstAddrBus-1:0] pc_next;
    logic                   ce_reg;
    logic                   ce_next;

    logic                   redirect;
    logic [InstAddrBus-1:0] redirect_target;

    ifid_ctrl_e             ifid_ctrl;
    logic [InstAddrBus-1:0] ifid_pc;
    logic [InstBus-1:0]     ifid_inst;
    logic                   ifid_excp;

    // Redirect selection: a flush always wins; a branch only counts in
    // RUN and only while decode is not stalled (decode re-asserts it).
    always_comb begin
        redirect        = 1'b0;
        redirect_target = bus.flush_pc_i;
        if (bus.flush_i) begin
            redirect        = 1'b1;
            redirect_target = bus.flush_pc_i;
        end else if (state_reg == IF_RUN && bus.branch_flag_i && !bus.id_stall) begin
            redirect        = 1'b1;
            redirect_target = bus.branch_target_i;
        end
    end

    // Next-state, next-PC and IF/ID control decisions.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ce_next    = ce_reg;
        ifid_ctrl  = IFID_HOLD;
        ifid_pc    = pc_reg;
        ifid_inst  = bus.inst_i;
        ifid_excp  = 1'b0;

        case (state_reg)
            IF_BOOT: begin
                // One idle edge so the ROM is enabled before the first fetch.
                state_next = IF_RUN;
                ce_next    = ChipEnable;
                ifid_ctrl  = IFID_BUBBLE;
            end

            IF_RUN, IF_FAULT: begin
                if (redirect) begin
                    pc_next = redirect_target;
                    if (is_misaligned(redirect_target)) begin
                        // Park on the bad target and hand decode a faulting slot.
                        state_next = IF_FAULT;
                        ce_next    = ChipDisable;
                        ifid_ctrl  = IFID_LOAD;
                        ifid_pc    = redirect_target;
                        ifid_inst  = NOP_INST;
                        ifid_excp  = 1'b1;
                    end else begin
                        // Squash whatever was fetched on the old path.
                        state_next = IF_RUN;
                        ce_next    = ChipEnable;
                        ifid_ctrl  = IFID_BUBBLE;
                    end
                end else if (bus.id_stall) begin
                    // Covers both-stalled and the illegal id-only stall.
                    ifid_ctrl = IFID_HOLD;
                end else if (state_reg == IF_FAULT || bus.if_stall) begin
                    ifid_ctrl = IFID_BUBBLE;
                end else begin
                    ifid_ctrl = IFID_LOAD;
                    ifid_pc   = pc_reg;
                    ifid_inst = bus.inst_i;
                    pc_next   = pc_reg + 32'd4;
                end
            end

            default: begin
                // Unreachable encoding: recover through BOOT.
                state_next = IF_BOOT;
                pc_next    = RESET_PC;
                ce_next    = ChipDisable;
                ifid_ctrl  = IFID_BUBBLE;
            end
        endcase
    end

    // Fetch FSM with registered PC and chip enable.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_reg <= IF_BOOT;
            pc_reg    <= RESET_PC;
            ce_reg    <= ChipDisable;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ce_reg    <= ce_next;
        end
    end

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ifid_ctrl),
        .load_pc  (ifid_pc),
        .load_inst(ifid_inst),
        .load_excp(ifid_excp),
        .id_pc    (bus.id_pc_o),
        .id_inst  (bus.id_inst_o),
        .id_valid (bus.id_valid_o),
        .id_excp  (bus.id_excp_o)
    );

    assign bus.pc_o = pc_reg;
    assign bus.ce_o = ce_reg;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the scalar RISC-V pipeline.
- Owns the program counter and drives the combinational instruction ROM, which returns `inst_i` in the same cycle as `pc_o`.
- Registers {pc, inst} into the IF/ID pipeline register for the decode stage.
- Handles stall, branch redirect, trap/flush redirect, and misaligned-target fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction injected as a bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- if_stall  in  1  hold PC (fetch stalled)
- id_stall  in  1  hold IF/ID register (decode stalled)
- branch_flag_i  in  1  taken branch/jump resolved in ID
- branch_target_i  in  32  redirect target for branch_flag_i
- flush_i  in  1  trap/exception flush from commit
- flush_pc_i  in  32  redirect target for flush_i
- inst_i  in  32  instruction returned by ROM for pc_o
- pc_o  out  32  fetch address to ROM
- ce_o  out  1  ROM chip enable (1 = enable)
- id_pc_o  out  32  registered PC of the instruction in ID
- id_inst_o  out  32  registered instruction in ID
- id_valid_o  out  1  id_inst_o is a real instruction, not a bubble
- id_excp_o  out  1  instruction-address-misaligned fault for id_pc_o

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_o=RESET_PC, ce_o=0, id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0, id_excp_o=0, state=BOOT.
- State machine states: BOOT, RUN, FAULT.
- BOOT:
  - First edge after reset release goes to RUN with ce_o<=1; pc_o stays RESET_PC; IF/ID gets a bubble.
  - First real fetch is RESET_PC, captured on the second edge.
- RUN, per edge, in priority order:
  1. flush_i: pc_o<=flush_pc_i; IF/ID<=bubble. Applies even if if_stall or id_stall is set.
  2. branch_flag_i && !id_stall: pc_o<=branch_target_i; IF/ID<=bubble, squashing the wrong-path fetch. No delay slot.
  3. if_stall && id_stall: pc_o and IF/ID hold.
  4. if_stall && !id_stall: pc_o holds; IF/ID<=bubble.
  5. !if_stall && id_stall: illegal combination. Treat as both stalled; the bench checks it never corrupts state.
  6. Otherwise: IF/ID<={pc_o, inst_i, valid=1}; pc_o<=pc_o+4, wrapping modulo 2^32 (FFFF_FFFC -> 0000_0000).
  - Ignored branch: branch_flag_i while id_stall=1 is ignored. The ID stage re-asserts it when unstalled.
- Misaligned redirect:
  - Trigger: a selected redirect target (flush_pc_i or branch_target_i) with bits[1:0]!=0.
  - Effect: pc_o<=target; ce_o<=0; IF/ID<={target, NOP_INST, valid=1, excp=1}; go to FAULT.
- FAULT:
  - ce_o=0; pc_o holds.
  - Held while id_stall=1; after the first non-stalled edge, IF/ID takes a bubble.
  - Only flush_i leaves FAULT: aligned flush_pc_i goes to RUN with ce_o=1; misaligned flush_pc_i repeats the fault.
- ce_o=0 (BOOT/FAULT): inst_i is ignored, since the ROM returns 0.
- Outputs: all outputs come straight from registers, with no combinational path from inputs to outputs. The only combinational path is pc_o to ROM to inst_i, which lands at the IF/ID register.
- Reset mid-operation: immediately returns every output to its reset value, regardless of stall/flush; resumes through BOOT.

Decomposition:
- Shared package (defines include), used everywhere:
  - InstAddrBus, InstBus widths; ZeroWord; ChipEnable/ChipDisable.
  - RstEnable redefined for active-low (1'b0).
  - NOP encoding; 2-bit state encodings IF_BOOT/IF_RUN/IF_FAULT.
- One sub-module is natural: `if_id_reg` (IF/ID register with hold/bubble/load controls).
- Next-PC selection and the FSM stay in if_stage.

Test Plan:
- Boot: release rst at t0, inst_i = 32'h0010_0093 @0, 32'h0020_0113 @4 -> ce_o=1 after edge 1; id_pc_o=0 / id_inst_o=00100093 / valid=1 after edge 2; id_pc_o=4 after edge 3.
- Stall: if_stall=1, id_stall=0 for 2 cycles at pc=8 -> pc_o stays 8, two bubbles (valid=0, NOP); release -> id_pc_o=8 next edge.
- Branch + priority: branch_flag_i=1, target=0x100 with flush_i=1, flush_pc_i=0x200 same edge -> pc_o=0x200, bubble. Branch alone with id_stall=1 -> ignored, pc holds.
- Misaligned: branch_target_i=0x102 -> id_excp_o=1, id_pc_o=0x102, ce_o=0, FAULT. Flush to 0x80 -> ce_o=1, fetch at 0x80 resumes.
- Wrap: flush to 0xFFFF_FFFC, run 2 cycles -> pc_o sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-run: drop rst between edges while pc=0x40 -> outputs reset immediately without a clock edge; reboot fetches RESET_PC.
